spu_load_store_unit: RTL and testbench

//  Quadword load/store sequencer sitting directly upstream of the SPU data memory.

---
 rtl/spu_ls_pkg.sv | 28 ++
 rtl/spu_ea_calc.sv | 19 +
 rtl/spu_load_store_unit.sv | 146 ++++++++++++++
 tb/tb_spu_load_store_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spu_ls_pkg.sv
// rtl/spu_ls_pkg.sv - shared types and constants for the SPU load/store path
package spu_ls_pkg;

    localparam int ADDR_W_DEFAULT = 32;
    localparam int DATA_W_DEFAULT = 128;
    localparam int RT_W_DEFAULT   = 7;
    localparam int CNT_W_DEFAULT  = 16;

    localparam int QWORD_BYTES = 16;

    localparam logic [31:0] LS_MASK_DEFAULT = 32'h0000_7FF0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } ls_state_t;

    typedef struct packed {
        logic         is_store;
        logic [31:0]  base;
        logic [31:0]  offset;
        logic [6:0]   rt;
        logic [127:0] data;
    } ls_req_t;

endpackage

// File: rtl/spu_ea_calc.sv
// rtl/spu_ea_calc.sv - effective address add-and-mask, shared with instruction fetch
import spu_ls_pkg::*;

module spu_ea_calc #(
    parameter int              ADDR_W = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] MASK = ADDR_W'(LS_MASK_DEFAULT)
) (
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] offset_i,
    output logic [ADDR_W-1:0] ea_o
);

    // Quadword alignment is forced even if a caller passes a mask that keeps low bits.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(QWORD_BYTES - 1);

    // Carry-out is dropped by the fixed-width add; the mask wraps into local store.
    assign ea_o = (base_i + offset_i) & MASK & ALIGN_MASK;

endmodule

// File: rtl/spu_load_store_unit.sv
// rtl/spu_load_store_unit.sv - quadword load/store sequencer in front of SPU data memory
import spu_ls_pkg::*;

module spu_load_store_unit #(
    parameter int                ADDR_W  = ADDR_W_DEFAULT,
    parameter int                DATA_W  = DATA_W_DEFAULT,
    parameter int                RT_W    = RT_W_DEFAULT,
    parameter logic [ADDR_W-1:0] LS_MASK = ADDR_W'(LS_MASK_DEFAULT),
    parameter int                CNT_W   = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [ADDR_W-1:0] req_base,
    input  logic [ADDR_W-1:0] req_offset,
    input  logic [RT_W-1:0]   req_rt,
    input  logic [DATA_W-1:0] req_store_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              wb_valid,
    output logic [RT_W-1:0]   wb_rt,
    output logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  load_count,
    output logic [CNT_W-1:0]  store_count
);

    ls_state_t         state_q, state_d;
    ls_req_t           req;
    logic [ADDR_W-1:0] ea;
    logic              accept;

    logic              is_store_q;
    logic [RT_W-1:0]   rt_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic [DATA_W-1:0] mem_write_data_q;
    logic              mem_write_q;
    logic              mem_read_q;
    logic              wb_valid_q;
    logic [RT_W-1:0]   wb_rt_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [CNT_W-1:0]  load_count_q;
    logic [CNT_W-1:0]  store_count_q;

    assign req.is_store = req_is_store;
    assign req.base     = req_base;
    assign req.offset   = req_offset;
    assign req.rt       = req_rt;
    assign req.data     = req_store_data;

    spu_ea_calc #(
        .ADDR_W (ADDR_W),
        .MASK   (LS_MASK)
    ) u_ea_calc (
        .base_i   (req.base),
        .offset_i (req.offset),
        .ea_o     (ea)
    );

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    // Next-state: a store retires straight out of ISSUE, a load waits for memory then writes back.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = is_store_q ? IDLE : WAIT;
            WAIT:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM and latched request; strobes are registered at accept so they are high exactly in ISSUE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            is_store_q       <= 1'b0;
            rt_q             <= '0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            mem_write_q      <= 1'b0;
            mem_read_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_write_q <= accept && req.is_store;
            mem_read_q  <= accept && !req.is_store;
            if (accept) begin
                is_store_q    <= req.is_store;
                rt_q          <= req.rt;
                mem_address_q <= ea;
                if (req.is_store) begin
                    mem_write_data_q <= req.data;
                end
            end
        end
    end

    // Writeback: data must be captured while WAIT is open, memory drives zero afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            wb_rt_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= (state_q == WB);
            if (state_q == WAIT) begin
                wb_data_q <= mem_read_data;
            end
            if (state_q == WB) begin
                wb_rt_q <= rt_q;
            end
        end
    end

    // Saturating event counters, one tick per completed op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_count_q  <= '0;
            store_count_q <= '0;
        end else begin
            if (state_q == ISSUE && is_store_q && store_count_q != '1) begin
                store_count_q <= store_count_q + CNT_W'(1);
            end
            if (state_q == WB && load_count_q != '1) begin
                load_count_q <= load_count_q + CNT_W'(1);
            end
        end
    end

    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;
    assign mem_write      = mem_write_q;
    assign mem_read       = mem_read_q;
    assign wb_valid       = wb_valid_q;
    assign wb_rt          = wb_rt_q;
    assign wb_data        = wb_data_q;
    assign load_count     = load_count_q;
    assign store_count    = store_count_q;

endmodule

// File: tb/tb_spu_load_store_unit.sv
// tb/tb_spu_load_store_unit.sv - self-checking bench for spu_load_store_unit
module tb_spu_load_store_unit;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic         req_is_store;
    logic [31:0]  req_base;
    logic [31:0]  req_offset;
    logic [6:0]   req_rt;
    logic [127:0] req_store_data;
    logic [31:0]  mem_address;
    logic [127:0] mem_write_data;
    logic         mem_write;
    logic         mem_read;
    logic [127:0] mem_read_data = '0;
    logic         wb_valid;
    logic [6:0]   wb_rt;
    logic [127:0] wb_data;
    logic [15:0]  load_count;
    logic [15:0]  store_count;

    int vectors = 0;
    int miscompares = 0;

    logic [127:0] mem_model [int unsigned];
    logic [127:0] ref_mem   [int unsigned];
    int unsigned  exp_loads  = 0;
    int unsigned  exp_stores = 0;

    logic         bb_active = 1'b0;
    logic [127:0] wb_q [$];
    logic [31:0]  wr_q [$];

    spu_load_store_unit dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_is_store   (req_is_store),
        .req_base       (req_base),
        .req_offset     (req_offset),
        .req_rt         (req_rt),
        .req_store_data (req_store_data),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data),
        .wb_valid       (wb_valid),
        .wb_rt          (wb_rt),
        .wb_data        (wb_data),
        .load_count     (load_count),
        .store_count    (store_count)
    );

    always #5 clk = ~clk;

    // Data memory: write on strobe, read data registered, zero when not reading.
    always @(posedge clk) begin
        if (mem_write) mem_model[mem_address] = mem_write_data;
        if (mem_read)
            mem_read_data <= mem_model.exists(mem_address) ? mem_model[mem_address] : '0;
        else
            mem_read_data <= '0;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ea_of(input logic [31:0] b, input logic [31:0] o);
        logic [31:0] sum;
        sum = b + o;
        return (sum % 32'h8000) / 16 * 16;
    endfunction

    function automatic logic [127:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    function automatic logic [15:0] sat16(input int unsigned n);
        return (n > 32'hFFFF) ? 16'hFFFF : n[15:0];
    endfunction

    always @(negedge clk) begin
        if (bb_active) begin
            check("no_overlap", {127'd0, mem_write && mem_read}, 128'd0);
            if (wb_valid) wb_q.push_back(wb_data);
            if (mem_write) wr_q.push_back(mem_address);
        end
    end

    task automatic present(input logic st, input logic [31:0] b, input logic [31:0] o,
                           input logic [6:0] rt, input logic [127:0] d);
        req_valid      = 1'b1;
        req_is_store   = st;
        req_base       = b;
        req_offset     = o;
        req_rt         = rt;
        req_store_data = d;
    endtask

    task automatic do_store(input logic [31:0] b, input logic [31:0] o, input logic [127:0] d);
        logic [31:0] ea;
        ea = ea_of(b, o);
        @(negedge clk);
        present(1'b1, b, o, 7'd0, d);
        #1 check("st_ready_before", {127'd0, req_ready}, 128'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("st_mem_write", {127'd0, mem_write}, 128'd1);
        check("st_mem_read", {127'd0, mem_read}, 128'd0);
        check("st_addr", {96'd0, mem_address}, {96'd0, ea});
        check("st_wdata", mem_write_data, d);
        check("st_busy", {127'd0, req_ready}, 128'd0);
        ref_mem[ea] = d;
        exp_stores++;
        @(negedge clk);
        check("st_write_drop", {127'd0, mem_write}, 128'd0);
        check("st_ready_after", {127'd0, req_ready}, 128'd1);
        check("st_count", {112'd0, store_count}, {112'd0, sat16(exp_stores)});
        check("st_addr_hold", {96'd0, mem_address}, {96'd0, ea});
    endtask

    task automatic do_load(input logic [31:0] b, input logic [31:0] o, input logic [6:0] rt);
        logic [31:0] ea;
        ea = ea_of(b, o);
        @(negedge clk);
        present(1'b0, b, o, rt, 128'd0);
        #1 check("ld_ready_before", {127'd0, req_ready}, 128'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("ld_mem_read", {127'd0, mem_read}, 128'd1);
        check("ld_mem_write", {127'd0, mem_write}, 128'd0);
        check("ld_addr", {96'd0, mem_address}, {96'd0, ea});
        @(negedge clk);
        check("ld_read_drop", {127'd0, mem_read}, 128'd0);
        check("ld_wb_early1", {127'd0, wb_valid}, 128'd0);
        @(negedge clk);
        check("ld_wb_early2", {127'd0, wb_valid}, 128'd0);
        check("ld_busy", {127'd0, req_ready}, 128'd0);
        exp_loads++;
        @(negedge clk);
        check("ld_wb_valid", {127'd0, wb_valid}, 128'd1);
        check("ld_wb_rt", {121'd0, wb_rt}, {121'd0, rt});
        check("ld_wb_data", wb_data, ref_read(ea));
        check("ld_count", {112'd0, load_count}, {112'd0, sat16(exp_loads)});
        check("ld_ready_after", {127'd0, req_ready}, 128'd1);
        @(negedge clk);
        check("ld_wb_pulse", {127'd0, wb_valid}, 128'd0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_ready"}, {127'd0, req_ready}, 128'd1);
        check({tag, "_mw"}, {127'd0, mem_write}, 128'd0);
        check({tag, "_mr"}, {127'd0, mem_read}, 128'd0);
        check({tag, "_addr"}, {96'd0, mem_address}, 128'd0);
        check({tag, "_wdata"}, mem_write_data, 128'd0);
        check({tag, "_wbv"}, {127'd0, wb_valid}, 128'd0);
        check({tag, "_wbrt"}, {121'd0, wb_rt}, 128'd0);
        check({tag, "_wbdata"}, wb_data, 128'd0);
        check({tag, "_lcnt"}, {112'd0, load_count}, 128'd0);
        check({tag, "_scnt"}, {112'd0, store_count}, 128'd0);
    endtask

    initial begin
        logic [31:0]  a_base [3];
        logic [127:0] d;
        logic [31:0]  b, o;
        int           budget;

        reset = 1'b1;
        present(1'b0, 32'd0, 32'd0, 7'd0, 128'd0);
        req_valid = 1'b0;
        #12;
        check_cleared("reset");
        @(negedge clk);
        reset = 1'b0;

        // Directed store then load of the same quadword.
        d = {32'hDEAD_0123, 32'h4567_89AB, 32'hCDEF_0011, 32'h2233_BEEF};
        do_store(32'h100, 32'h20, d);
        check("ea_0x120", {96'd0, mem_address}, 128'h120);
        do_load(32'h100, 32'h20, 7'd5);
        check("wb_dead_beef", wb_data, d);

        // Mask wrap and negative offset.
        do_store(32'h7FF8, 32'h1C, 128'hA5A5);
        check("ea_wrap", {96'd0, mem_address}, 128'h10);
        do_store(32'h10, 32'hFFFF_FFE0, 128'h5A5A);
        check("ea_neg", {96'd0, mem_address}, 128'h7FF0);

        // Random store/load pairs.
        for (int i = 0; i < 8; i++) begin
            b = $urandom;
            o = $urandom;
            d = {$urandom, $urandom, $urandom, $urandom};
            do_store(b, o, d);
            do_load($urandom_range(0, 32'h7FFF), $urandom_range(0, 32'h7FFF), 7'($urandom));
            do_load(b, o, 7'($urandom));
        end

        // Back-to-back with req_valid held: load, load, store.
        a_base[0] = 32'h100;
        a_base[1] = 32'h7FF8;
        a_base[2] = 32'h3330;
        d = {$urandom, $urandom, $urandom, $urandom};
        wb_q.delete();
        wr_q.delete();
        @(negedge clk);
        bb_active = 1'b1;
        for (int k = 0; k < 3; k++) begin
            present(k == 2, a_base[k], (k == 1) ? 32'h1C : 32'h20, 7'(k + 1), d);
            budget = 0;
            #1;
            while (!req_ready && budget < 10) begin
                @(negedge clk);
                #1 budget++;
            end
            check("bb_accept_bound", {127'd0, req_ready}, 128'd1);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        repeat (8) @(negedge clk);
        bb_active = 1'b0;
        check("bb_wb_count", 128'(wb_q.size()), 128'd2);
        check("bb_wr_count", 128'(wr_q.size()), 128'd1);
        if (wb_q.size() == 2) begin
            check("bb_wb0", wb_q[0], ref_read(ea_of(32'h100, 32'h20)));
            check("bb_wb1", wb_q[1], ref_read(ea_of(32'h7FF8, 32'h1C)));
        end
        if (wr_q.size() == 1) check("bb_wr0", {96'd0, wr_q[0]}, {96'd0, ea_of(32'h3330, 32'h20)});
        ref_mem[ea_of(32'h3330, 32'h20)] = d;
        exp_loads += 2;
        exp_stores++;
        check("bb_lcnt", {112'd0, load_count}, {112'd0, sat16(exp_loads)});
        check("bb_scnt", {112'd0, store_count}, {112'd0, sat16(exp_stores)});

        // Reset during WAIT of a load.
        @(negedge clk);
        present(1'b0, 32'h100, 32'h20, 7'd9, 128'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1 check_cleared("midop");
        exp_loads  = 0;
        exp_stores = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("midop_no_wb", {127'd0, wb_valid}, 128'd0);
        end
        do_load(32'h100, 32'h20, 7'd11);

        // Saturation of store_count.
        @(negedge clk);
        force dut.store_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.store_count_q;
        exp_stores = 32'hFFFF;
        for (int i = 0; i < 3; i++) do_store($urandom, $urandom, {4{$urandom}});
        check("sat_final", {112'd0, store_count}, 128'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
